csi2_pixel_unpacker: RTL and testbench

- Sits directly downstream of the CSI-2 receiver packet stage and consumes its byte stream (raw_data/valid/sop/eop/vc/dt).
- Filters packets by virtual channel and data type, and unpacks RAW8/RAW10/RAW12 payload bytes into left-justified pixels.
- Tags first and last pixel of each packet.
- Buffers output in a FIFO with valid/ready backpressure toward the ISP front end. The upstream stage has no backpressure, so loss is flagged rather than prevented.

---
 rtl/csi2_pixel_unpacker.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_csi2_pixel_unpacker.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2_pixel_unpacker.sv
// csi2_pixel_unpacker: filters CSI-2 payload packets by virtual channel and
// data type, unpacks RAW8/RAW10/RAW12 bytes into left-justified 12-bit pixels,
// tags packet boundaries and buffers pixels toward a valid/ready consumer.
module csi2_pixel_unpacker #(
    parameter int DATA_WIDTH = 16,
    parameter int PIX_WIDTH  = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] raw_data_i,
    input  logic                  raw_valid_i,
    input  logic                  raw_sop_i,
    input  logic                  raw_eop_i,
    input  logic [1:0]            raw_vc_i,
    input  logic [5:0]            raw_dt_i,
    input  logic [1:0]            cfg_vc_i,
    input  logic                  err_clr_i,
    output logic [PIX_WIDTH-1:0]  pix_data_o,
    output logic                  pix_valid_o,
    input  logic                  pix_ready_i,
    output logic                  pix_sop_o,
    output logic                  pix_eop_o,
    output logic [5:0]            pix_dt_o,
    output logic                  overflow_o,
    output logic                  len_err_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = PIX_WIDTH + 2 + 6;

    localparam logic [5:0] DT_RAW8  = 6'h2A;
    localparam logic [5:0] DT_RAW10 = 6'h2B;
    localparam logic [5:0] DT_RAW12 = 6'h2C;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ACTIVE,
        DROP,
        FLUSH
    } state_t;

    state_t                 state_q, state_d;
    logic                   sop_pend_q, sop_pend_d;
    logic [5:0]             dt_q, dt_d;
    logic [2:0]             k_q, k_d;
    logic [7:0]             byte_q [4];
    logic [7:0]             byte_d [4];
    logic                   first_q, first_d;
    logic [PIX_WIDTH-1:0]   stg_mem_q [8];
    logic [PIX_WIDTH-1:0]   stg_mem_d [8];
    logic [2:0]             stg_rd_q, stg_rd_d;
    logic [2:0]             stg_wr_q, stg_wr_d;
    logic [3:0]             stg_cnt_q, stg_cnt_d;
    logic [EW-1:0]          fifo_mem_q [FIFO_DEPTH];
    logic [EW-1:0]          fifo_mem_d [FIFO_DEPTH];
    logic [AW-1:0]          fifo_rd_q, fifo_rd_d;
    logic [AW-1:0]          fifo_wr_q, fifo_wr_d;
    logic                   ovf_q, ovf_d;
    logic                   len_err_q, len_err_d;

    logic [7:0]             cur_byte;
    logic                   fmt_ok;
    logic [5:0]             fmt_dt;
    logic [2:0]             k_cur;
    logic                   byte_take;
    logic [2:0]             grp_n;
    logic [PIX_WIDTH-1:0]   grp_pix [4];
    logic [2:0]             k_next;
    logic                   fifo_valid;
    logic                   fifo_full;
    logic                   fifo_pop;
    logic                   fifo_space;
    logic                   stg_move;
    logic [3:0]             stg_free;
    logic                   grp_fit;
    logic                   stg_write;
    logic                   ovf_set;
    logic                   len_err_set;
    logic [EW-1:0]          push_entry;
    logic [EW-1:0]          head;

    // Only the low byte of the upstream bus carries payload.
    generate
        if (DATA_WIDTH > 8) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^raw_data_i[DATA_WIDTH-1:8];
        end
    endgenerate

    assign cur_byte  = raw_data_i[7:0];
    assign fmt_ok    = (raw_vc_i == cfg_vc_i) &&
                       ((raw_dt_i == DT_RAW8) || (raw_dt_i == DT_RAW10) || (raw_dt_i == DT_RAW12));
    assign fmt_dt    = (state_q == ARM) ? raw_dt_i : dt_q;
    assign k_cur     = (state_q == ARM) ? 3'd0 : k_q;
    assign byte_take = raw_valid_i && ((state_q == ACTIVE) || ((state_q == ARM) && fmt_ok));

    assign fifo_valid = (fifo_wr_q != fifo_rd_q);
    assign fifo_full  = ((fifo_wr_q + AW'(1)) == fifo_rd_q);
    assign fifo_pop   = fifo_valid && pix_ready_i;
    assign fifo_space = !fifo_full || fifo_pop;
    assign head       = fifo_mem_q[fifo_rd_q];

    // Assemble a complete pixel group from the current byte and the stored group bytes.
    always_comb begin
        grp_n   = 3'd0;
        k_next  = k_cur;
        byte_d  = byte_q;
        for (int i = 0; i < 4; i++) begin
            grp_pix[i] = '0;
        end
        if (byte_take) begin
            case (fmt_dt)
                DT_RAW8: begin
                    grp_n      = 3'd1;
                    grp_pix[0] = {cur_byte, 4'h0};
                    k_next     = 3'd0;
                end
                DT_RAW10: begin
                    if (k_cur == 3'd4) begin
                        grp_n      = 3'd4;
                        grp_pix[0] = {byte_q[0], cur_byte[1:0], 2'b00};
                        grp_pix[1] = {byte_q[1], cur_byte[3:2], 2'b00};
                        grp_pix[2] = {byte_q[2], cur_byte[5:4], 2'b00};
                        grp_pix[3] = {byte_q[3], cur_byte[7:6], 2'b00};
                        k_next     = 3'd0;
                    end else begin
                        byte_d[k_cur[1:0]] = cur_byte;
                        k_next             = k_cur + 3'd1;
                    end
                end
                default: begin
                    if (k_cur == 3'd2) begin
                        grp_n      = 3'd2;
                        grp_pix[0] = {byte_q[0], cur_byte[3:0]};
                        grp_pix[1] = {byte_q[1], cur_byte[7:4]};
                        k_next     = 3'd0;
                    end else begin
                        byte_d[k_cur[1:0]] = cur_byte;
                        k_next             = k_cur + 3'd1;
                    end
                end
            endcase
        end
    end

    // Packet FSM, staging buffer, output FIFO and sticky flag next-state logic.
    always_comb begin
        state_d     = state_q;
        sop_pend_d  = sop_pend_q;
        dt_d        = dt_q;
        k_d         = k_next;
        first_d     = first_q;
        stg_mem_d   = stg_mem_q;
        stg_rd_d    = stg_rd_q;
        stg_wr_d    = stg_wr_q;
        stg_cnt_d   = stg_cnt_q;
        fifo_mem_d  = fifo_mem_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_wr_d   = fifo_wr_q;
        ovf_set     = 1'b0;
        len_err_set = 1'b0;

        // The newest pixel stays in staging while the packet is open so eop can be tagged on it.
        stg_move = fifo_space &&
                   (((state_q == ACTIVE) && (stg_cnt_q >= 4'd2)) ||
                    ((state_q == FLUSH) && (stg_cnt_q != 4'd0)));
        stg_free  = 4'd8 - stg_cnt_q + {3'b000, stg_move};
        grp_fit   = ({1'b0, grp_n} <= stg_free);
        stg_write = (grp_n != 3'd0) && grp_fit;
        if ((grp_n != 3'd0) && !grp_fit) begin
            ovf_set = 1'b1;
        end
        if (raw_valid_i && (state_q == FLUSH)) begin
            ovf_set = 1'b1;
        end

        if (stg_write) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < grp_n) begin
                    stg_mem_d[stg_wr_q + 3'(i)] = grp_pix[i];
                end
            end
            stg_wr_d = stg_wr_q + grp_n;
        end
        if (stg_move) begin
            stg_rd_d = stg_rd_q + 3'd1;
            first_d  = 1'b0;
        end
        stg_cnt_d = stg_cnt_q + (stg_write ? {1'b0, grp_n} : 4'd0) - {3'b000, stg_move};

        push_entry = {stg_mem_q[stg_rd_q], first_q,
                      (state_q == FLUSH) && (stg_cnt_q == 4'd1), dt_q};
        if (stg_move) begin
            fifo_mem_d[fifo_wr_q] = push_entry;
            fifo_wr_d             = fifo_wr_q + AW'(1);
        end
        if (fifo_pop) begin
            fifo_rd_d = fifo_rd_q + AW'(1);
        end

        case (state_q)
            IDLE: begin
                if (raw_sop_i) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (raw_valid_i) begin
                    dt_d = raw_dt_i;
                    if (fmt_ok) begin
                        state_d = ACTIVE;
                        first_d = 1'b1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            ACTIVE: begin
                if (raw_sop_i) begin
                    len_err_set = 1'b1;
                    sop_pend_d  = 1'b1;
                    k_d         = 3'd0;
                    state_d     = FLUSH;
                end else if (raw_eop_i) begin
                    if (k_q != 3'd0) begin
                        len_err_set = 1'b1;
                    end
                    k_d     = 3'd0;
                    state_d = FLUSH;
                end
            end
            DROP: begin
                if (raw_sop_i) begin
                    state_d = ARM;
                end else if (raw_eop_i) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (raw_sop_i) begin
                    sop_pend_d = 1'b1;
                end
                if (stg_cnt_q == 4'd0) begin
                    state_d    = (sop_pend_q || raw_sop_i) ? ARM : IDLE;
                    sop_pend_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ovf_d     = ovf_set || (ovf_q && !err_clr_i);
        len_err_d = len_err_set || (len_err_q && !err_clr_i);
    end

    // Control state register; reset empties both buffers by clearing their pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            sop_pend_q <= 1'b0;
            dt_q       <= '0;
            k_q        <= '0;
            first_q    <= 1'b0;
            stg_rd_q   <= '0;
            stg_wr_q   <= '0;
            stg_cnt_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            ovf_q      <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sop_pend_q <= sop_pend_d;
            dt_q       <= dt_d;
            k_q        <= k_d;
            first_q    <= first_d;
            stg_rd_q   <= stg_rd_d;
            stg_wr_q   <= stg_wr_d;
            stg_cnt_q  <= stg_cnt_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            ovf_q      <= ovf_d;
            len_err_q  <= len_err_d;
        end
    end

    // Storage arrays need no reset; their contents are only visible through the pointers.
    always_ff @(posedge clk_i) begin
        byte_q     <= byte_d;
        stg_mem_q  <= stg_mem_d;
        fifo_mem_q <= fifo_mem_d;
    end

    assign pix_valid_o = fifo_valid;
    assign pix_data_o  = fifo_valid ? head[EW-1:8] : '0;
    assign pix_sop_o   = fifo_valid && head[7];
    assign pix_eop_o   = fifo_valid && head[6];
    assign pix_dt_o    = fifo_valid ? head[5:0] : 6'h00;
    assign overflow_o  = ovf_q;
    assign len_err_o   = len_err_q;

endmodule

// File: tb/tb_csi2_pixel_unpacker.sv
// Directed testbench for csi2_pixel_unpacker: each task drives one scenario
// and compares captured pixels and flags against hand-computed values.
module tb_csi2_pixel_unpacker;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] raw_data_i = '0;
    logic        raw_valid_i = 1'b0;
    logic        raw_sop_i = 1'b0;
    logic        raw_eop_i = 1'b0;
    logic [1:0]  raw_vc_i = '0;
    logic [5:0]  raw_dt_i = '0;
    logic [1:0]  cfg_vc_i = '0;
    logic        err_clr_i = 1'b0;
    logic [11:0] pix_data_o;
    logic        pix_valid_o;
    logic        pix_ready_i = 1'b1;
    logic        pix_sop_o;
    logic        pix_eop_o;
    logic [5:0]  pix_dt_o;
    logic        overflow_o;
    logic        len_err_o;

    typedef struct packed {
        logic [11:0] data;
        logic        sop;
        logic        eop;
        logic [5:0]  dt;
    } pix_t;

    pix_t got[$];
    int   got_cyc[$];
    pix_t exp_q[$];
    int   cyc = 0;
    int   valid_seen = 0;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    csi2_pixel_unpacker dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .raw_data_i  (raw_data_i),
        .raw_valid_i (raw_valid_i),
        .raw_sop_i   (raw_sop_i),
        .raw_eop_i   (raw_eop_i),
        .raw_vc_i    (raw_vc_i),
        .raw_dt_i    (raw_dt_i),
        .cfg_vc_i    (cfg_vc_i),
        .err_clr_i   (err_clr_i),
        .pix_data_o  (pix_data_o),
        .pix_valid_o (pix_valid_o),
        .pix_ready_i (pix_ready_i),
        .pix_sop_o   (pix_sop_o),
        .pix_eop_o   (pix_eop_o),
        .pix_dt_o    (pix_dt_o),
        .overflow_o  (overflow_o),
        .len_err_o   (len_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Capture every accepted pixel on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (pix_valid_o) valid_seen++;
            if (pix_valid_o && pix_ready_i) begin
                got.push_back(pix_t'{pix_data_o, pix_sop_o, pix_eop_o, pix_dt_o});
                got_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_sop();
        raw_sop_i = 1'b1;
        tick();
        raw_sop_i = 1'b0;
    endtask

    task automatic send_eop();
        raw_eop_i = 1'b1;
        tick();
        raw_eop_i = 1'b0;
    endtask

    task automatic send_byte(input logic [1:0] vc, input logic [5:0] dt, input logic [7:0] b);
        raw_valid_i = 1'b1;
        raw_vc_i    = vc;
        raw_dt_i    = dt;
        raw_data_i  = {8'hC3, b};
        tick();
        raw_valid_i = 1'b0;
        raw_data_i  = '0;
    endtask

    task automatic expect_pix(input logic [11:0] d, input logic s, input logic e, input logic [5:0] dt);
        exp_q.push_back(pix_t'{d, s, e, dt});
    endtask

    task automatic wait_pixels(input int n, input int budget);
        int b = 0;
        while (got.size() < n && b < budget) begin
            tick();
            b++;
        end
    endtask

    task automatic clear_capture();
        got.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        vec_cnt++;
        if ({pix_valid_o, pix_data_o, pix_sop_o, pix_eop_o, pix_dt_o, overflow_o, len_err_o} !== 23'd0) begin
            err_cnt++;
            $display("[TB] FAIL reset_outputs: got valid=%b data=%h sop=%b eop=%b dt=%h ovf=%b len=%b, want all 0",
                     pix_valid_o, pix_data_o, pix_sop_o, pix_eop_o, pix_dt_o, overflow_o, len_err_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_raw8();
        int t_b2;
        clear_capture();
        pix_ready_i = 1'b1;
        send_sop();
        send_byte(2'd0, 6'h2A, 8'h01);
        t_b2 = cyc;
        send_byte(2'd0, 6'h2A, 8'h02);
        send_byte(2'd0, 6'h2A, 8'h03);
        send_byte(2'd0, 6'h2A, 8'h04);
        send_eop();
        wait_pixels(4, 50);
        repeat (3) tick();
        vec_cnt++;
        if (got.size() != 4) begin
            err_cnt++;
            $display("[TB] FAIL raw8_count: got %0d pixels, want 4", got.size());
        end
        while (got.size() < 4) begin got.push_back('0); got_cyc.push_back(0); end
        expect_pix(12'h010, 1'b1, 1'b0, 6'h2A);
        expect_pix(12'h020, 1'b0, 1'b0, 6'h2A);
        expect_pix(12'h030, 1'b0, 1'b0, 6'h2A);
        expect_pix(12'h040, 1'b0, 1'b1, 6'h2A);
        for (int i = 0; i < 4; i++) begin
            vec_cnt++;
            if (got[i] !== exp_q[i]) begin
                err_cnt++;
                $display("[TB] FAIL raw8_pix%0d: got %h/%b/%b/%h, want %h/%b/%b/%h", i,
                         got[i].data, got[i].sop, got[i].eop, got[i].dt,
                         exp_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].dt);
            end
        end
        vec_cnt++;
        if (got_cyc[1] != t_b2 + 3) begin
            err_cnt++;
            $display("[TB] FAIL raw8_latency: got cycle %0d, want %0d", got_cyc[1], t_b2 + 3);
        end
        vec_cnt++;
        if ({overflow_o, len_err_o} !== 2'b00) begin
            err_cnt++;
            $display("[TB] FAIL raw8_flags: got ovf=%b len=%b, want 0/0", overflow_o, len_err_o);
        end
    endtask

    task automatic test_raw10();
        clear_capture();
        send_sop();
        send_byte(2'd0, 6'h2B, 8'hAA);
        send_byte(2'd0, 6'h2B, 8'hBB);
        send_byte(2'd0, 6'h2B, 8'hCC);
        send_byte(2'd0, 6'h2B, 8'hDD);
        send_byte(2'd0, 6'h2B, 8'hE4);
        send_eop();
        wait_pixels(4, 50);
        while (got.size() < 4) got.push_back('0);
        // 0xE4 supplies low pairs 00, 01, 10, 11 for P0..P3.
        expect_pix(12'hAA0, 1'b1, 1'b0, 6'h2B);
        expect_pix(12'hBB4, 1'b0, 1'b0, 6'h2B);
        expect_pix(12'hCC8, 1'b0, 1'b0, 6'h2B);
        expect_pix(12'hDDC, 1'b0, 1'b1, 6'h2B);
        for (int i = 0; i < 4; i++) begin
            vec_cnt++;
            if (got[i] !== exp_q[i]) begin
                err_cnt++;
                $display("[TB] FAIL raw10_pix%0d: got %h/%b/%b/%h, want %h/%b/%b/%h", i,
                         got[i].data, got[i].sop, got[i].eop, got[i].dt,
                         exp_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].dt);
            end
        end
    endtask

    task automatic test_raw12_backpressure();
        logic changed;
        clear_capture();
        pix_ready_i = 1'b0;
        send_sop();
        send_byte(2'd0, 6'h2C, 8'h12);
        send_byte(2'd0, 6'h2C, 8'h34);
        send_byte(2'd0, 6'h2C, 8'hA5);
        send_eop();
        repeat (4) tick();
        vec_cnt++;
        if ({pix_valid_o, pix_data_o, pix_sop_o} !== {1'b1, 12'h125, 1'b1}) begin
            err_cnt++;
            $display("[TB] FAIL raw12_held_head: got valid=%b data=%h sop=%b, want 1/125/1",
                     pix_valid_o, pix_data_o, pix_sop_o);
        end
        changed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ({pix_valid_o, pix_data_o, pix_sop_o, pix_eop_o} !== {1'b1, 12'h125, 1'b1, 1'b0}) changed = 1'b1;
        end
        vec_cnt++;
        if (changed !== 1'b0) begin
            err_cnt++;
            $display("[TB] FAIL raw12_stable: got output change while stalled, want stable");
        end
        pix_ready_i = 1'b1;
        wait_pixels(2, 30);
        repeat (3) tick();
        vec_cnt++;
        if (got.size() != 2) begin
            err_cnt++;
            $display("[TB] FAIL raw12_count: got %0d pixels, want 2", got.size());
        end
        while (got.size() < 2) got.push_back('0);
        expect_pix(12'h125, 1'b1, 1'b0, 6'h2C);
        expect_pix(12'h34A, 1'b0, 1'b1, 6'h2C);
        for (int i = 0; i < 2; i++) begin
            vec_cnt++;
            if (got[i] !== exp_q[i]) begin
                err_cnt++;
                $display("[TB] FAIL raw12_pix%0d: got %h/%b/%b/%h, want %h/%b/%b/%h", i,
                         got[i].data, got[i].sop, got[i].eop, got[i].dt,
                         exp_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].dt);
            end
        end
    endtask

    task automatic test_filter();
        clear_capture();
        valid_seen = 0;
        send_sop();
        send_byte(2'd1, 6'h2A, 8'h11);
        send_byte(2'd1, 6'h2A, 8'h22);
        send_eop();
        send_sop();
        send_byte(2'd0, 6'h1E, 8'h33);
        send_byte(2'd0, 6'h1E, 8'h44);
        send_eop();
        repeat (10) tick();
        vec_cnt++;
        if (valid_seen != 0) begin
            err_cnt++;
            $display("[TB] FAIL filter_no_output: got %0d valid cycles, want 0", valid_seen);
        end
        vec_cnt++;
        if ({overflow_o, len_err_o} !== 2'b00) begin
            err_cnt++;
            $display("[TB] FAIL filter_flags: got ovf=%b len=%b, want 0/0", overflow_o, len_err_o);
        end
        send_sop();
        send_byte(2'd0, 6'h2A, 8'h55);
        send_byte(2'd0, 6'h2A, 8'h66);
        send_eop();
        wait_pixels(2, 50);
        while (got.size() < 2) got.push_back('0);
        expect_pix(12'h550, 1'b1, 1'b0, 6'h2A);
        expect_pix(12'h660, 1'b0, 1'b1, 6'h2A);
        for (int i = 0; i < 2; i++) begin
            vec_cnt++;
            if (got[i] !== exp_q[i]) begin
                err_cnt++;
                $display("[TB] FAIL filter_pix%0d: got %h/%b/%b/%h, want %h/%b/%b/%h", i,
                         got[i].data, got[i].sop, got[i].eop, got[i].dt,
                         exp_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].dt);
            end
        end
    endtask

    task automatic test_len_err();
        clear_capture();
        send_sop();
        send_byte(2'd0, 6'h2B, 8'h10);
        send_byte(2'd0, 6'h2B, 8'h20);
        send_byte(2'd0, 6'h2B, 8'h30);
        send_byte(2'd0, 6'h2B, 8'h40);
        send_byte(2'd0, 6'h2B, 8'hFF);
        send_byte(2'd0, 6'h2B, 8'h50);
        send_byte(2'd0, 6'h2B, 8'h60);
        send_eop();
        wait_pixels(4, 50);
        repeat (5) tick();
        vec_cnt++;
        if (got.size() != 4) begin
            err_cnt++;
            $display("[TB] FAIL lenerr_count: got %0d pixels, want 4", got.size());
        end
        while (got.size() < 4) got.push_back('0);
        expect_pix(12'h10C, 1'b1, 1'b0, 6'h2B);
        expect_pix(12'h20C, 1'b0, 1'b0, 6'h2B);
        expect_pix(12'h30C, 1'b0, 1'b0, 6'h2B);
        expect_pix(12'h40C, 1'b0, 1'b1, 6'h2B);
        for (int i = 0; i < 4; i++) begin
            vec_cnt++;
            if (got[i] !== exp_q[i]) begin
                err_cnt++;
                $display("[TB] FAIL lenerr_pix%0d: got %h/%b/%b/%h, want %h/%b/%b/%h", i,
                         got[i].data, got[i].sop, got[i].eop, got[i].dt,
                         exp_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].dt);
            end
        end
        vec_cnt++;
        if ({overflow_o, len_err_o} !== 2'b01) begin
            err_cnt++;
            $display("[TB] FAIL lenerr_flag_set: got ovf=%b len=%b, want 0/1", overflow_o, len_err_o);
        end
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        vec_cnt++;
        if (len_err_o !== 1'b0) begin
            err_cnt++;
            $display("[TB] FAIL lenerr_clear: got len=%b, want 0", len_err_o);
        end
    endtask

    task automatic test_overflow_reset();
        clear_capture();
        pix_ready_i = 1'b0;
        send_sop();
        for (int i = 0; i < 40; i++) send_byte(2'd0, 6'h2A, 8'(i + 1));
        send_eop();
        repeat (5) tick();
        vec_cnt++;
        if ({overflow_o, len_err_o} !== 2'b10) begin
            err_cnt++;
            $display("[TB] FAIL ovf_flag_set: got ovf=%b len=%b, want 1/0", overflow_o, len_err_o);
        end
        pix_ready_i = 1'b1;
        wait_pixels(23, 200);
        repeat (10) tick();
        vec_cnt++;
        if (got.size() != 23) begin
            err_cnt++;
            $display("[TB] FAIL ovf_retained: got %0d pixels, want 23", got.size());
        end
        while (got.size() < 23) got.push_back('0);
        for (int i = 0; i < 23; i++) expect_pix({8'(i + 1), 4'h0}, i == 0, i == 22, 6'h2A);
        for (int i = 0; i < 23; i++) begin
            vec_cnt++;
            if (got[i] !== exp_q[i]) begin
                err_cnt++;
                $display("[TB] FAIL ovf_pix%0d: got %h/%b/%b/%h, want %h/%b/%b/%h", i,
                         got[i].data, got[i].sop, got[i].eop, got[i].dt,
                         exp_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].dt);
            end
        end
        // Reset in the middle of a stalled packet with the overflow flag still set.
        pix_ready_i = 1'b0;
        send_sop();
        for (int i = 0; i < 5; i++) send_byte(2'd0, 6'h2A, 8'(8'h80 + i));
        rst_i = 1'b1;
        tick();
        vec_cnt++;
        if ({pix_valid_o, pix_data_o, pix_sop_o, pix_eop_o, pix_dt_o, overflow_o, len_err_o} !== 23'd0) begin
            err_cnt++;
            $display("[TB] FAIL midreset_outputs: got valid=%b data=%h sop=%b eop=%b dt=%h ovf=%b len=%b, want all 0",
                     pix_valid_o, pix_data_o, pix_sop_o, pix_eop_o, pix_dt_o, overflow_o, len_err_o);
        end
        rst_i = 1'b0;
        tick();
        clear_capture();
        pix_ready_i = 1'b1;
        send_sop();
        send_byte(2'd0, 6'h2A, 8'h77);
        send_eop();
        wait_pixels(1, 50);
        repeat (5) tick();
        vec_cnt++;
        if (got.size() != 1) begin
            err_cnt++;
            $display("[TB] FAIL postreset_count: got %0d pixels, want 1", got.size());
        end
        while (got.size() < 1) got.push_back('0);
        vec_cnt++;
        if (got[0] !== pix_t'{12'h770, 1'b1, 1'b1, 6'h2A}) begin
            err_cnt++;
            $display("[TB] FAIL postreset_pix: got %h/%b/%b/%h, want 770/1/1/2a",
                     got[0].data, got[0].sop, got[0].eop, got[0].dt);
        end
    endtask

    initial begin
        test_reset();
        test_raw8();
        test_raw10();
        test_raw12_backpressure();
        test_filter();
        test_len_err();
        test_overflow_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
